// File: rtl/bf_pkg.sv
// Shared bf CPU definitions: loop-stack command encodings, sequencer states, default widths.
package bf_pkg;

    localparam int DEF_I_ADDR_WIDTH = 16;

    localparam logic [1:0] OP_FLUSH = 2'b00;
    localparam logic [1:0] OP_PUSH  = 2'b01;
    localparam logic [1:0] OP_POP   = 2'b10;
    localparam logic [1:0] OP_PEEK  = 2'b11;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_REFILL = 1'b1
    } loop_state_t;

endpackage

// File: rtl/loop_stack_ctrl.sv
// Loop-address stack sequencer: TOS lives in a register, the rest spills to the stack RAM,
// and a POP at depth>=2 spends one extra cycle reloading TOS from the RAM.
module loop_stack_ctrl
    import bf_pkg::*;
#(
    parameter int I_ADDR_WIDTH   = DEF_I_ADDR_WIDTH,
    parameter int MAX_LOOP_DEPTH = 256
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_op,
    input  logic [I_ADDR_WIDTH-1:0] cmd_data,
    output logic                    rsp_valid,
    output logic [I_ADDR_WIDTH-1:0] rsp_data,
    output logic                    rsp_err,
    output logic [31:0]             depth,
    output logic                    empty,
    output logic                    full,
    output logic                    err_overflow,
    output logic                    err_underflow,
    input  logic                    err_clear,
    output logic [31:0]             ram_write_addr,
    output logic                    ram_write_en,
    output logic [I_ADDR_WIDTH-1:0] ram_write_data,
    output logic [31:0]             ram_read_addr,
    input  logic [I_ADDR_WIDTH-1:0] ram_read_data
);

    loop_state_t             state;
    logic [I_ADDR_WIDTH-1:0] tos;
    logic                    accept;

    assign cmd_ready = (state == ST_IDLE) && rst_n;
    assign accept    = cmd_valid && cmd_ready;
    assign empty     = (depth == 32'd0);
    assign full      = (depth == 32'(MAX_LOOP_DEPTH));

    // Old TOS spills to RAM on a push; nothing to spill when the stack is empty.
    assign ram_write_en   = accept && (cmd_op == OP_PUSH) && !full && !empty;
    assign ram_write_addr = depth - 32'd1;
    assign ram_write_data = tos;

    // depth has already dropped by one in REFILL, so depth-1 holds the POP-time address.
    always_comb begin
        if (state == ST_REFILL)
            ram_read_addr = depth - 32'd1;
        else if (depth >= 32'd2)
            ram_read_addr = depth - 32'd2;
        else
            ram_read_addr = 32'd0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            depth         <= 32'd0;
            tos           <= '0;
            rsp_valid     <= 1'b0;
            rsp_err       <= 1'b0;
            rsp_data      <= '0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            // Clear first so a same-cycle set below takes precedence.
            if (err_clear) begin
                err_overflow  <= 1'b0;
                err_underflow <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        case (cmd_op)
                            OP_FLUSH: begin
                                depth <= 32'd0;
                                tos   <= '0;
                            end
                            OP_PUSH: begin
                                if (full) begin
                                    err_overflow <= 1'b1;
                                end else begin
                                    tos   <= cmd_data;
                                    depth <= depth + 32'd1;
                                end
                            end
                            default: begin
                                rsp_valid <= 1'b1;
                                if (empty) begin
                                    rsp_err       <= 1'b1;
                                    rsp_data      <= '0;
                                    err_underflow <= 1'b1;
                                end else begin
                                    rsp_data <= tos;
                                    if (cmd_op == OP_POP) begin
                                        depth <= depth - 32'd1;
                                        if (depth == 32'd1)
                                            tos <= '0;
                                        else
                                            state <= ST_REFILL;
                                    end
                                end
                            end
                        endcase
                    end
                end
                ST_REFILL: begin
                    tos   <= ram_read_data;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_loop_stack_ctrl.sv
// Scoreboarded bench for loop_stack_ctrl with a small registered-read stack RAM beside it.
module tb_loop_stack_ctrl;
    import bf_pkg::*;

    localparam int W   = 16;
    localparam int MAX = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [W-1:0]  cmd_data;
    logic          rsp_valid;
    logic [W-1:0]  rsp_data;
    logic          rsp_err;
    logic [31:0]   depth;
    logic          empty;
    logic          full;
    logic          err_overflow;
    logic          err_underflow;
    logic          err_clear;
    logic [31:0]   ram_write_addr;
    logic          ram_write_en;
    logic [W-1:0]  ram_write_data;
    logic [31:0]   ram_read_addr;
    logic [W-1:0]  ram_read_data;

    typedef struct packed {
        logic         err;
        logic [W-1:0] data;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] stk[$];
    logic         ovf_m, unf_m;
    int           n_chk = 0;
    int           n_fail = 0;

    logic [W-1:0] mem [0:MAX-2];

    always #5 clk = ~clk;

    loop_stack_ctrl #(.I_ADDR_WIDTH(W), .MAX_LOOP_DEPTH(MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .depth(depth), .empty(empty), .full(full),
        .err_overflow(err_overflow), .err_underflow(err_underflow), .err_clear(err_clear),
        .ram_write_addr(ram_write_addr), .ram_write_en(ram_write_en), .ram_write_data(ram_write_data),
        .ram_read_addr(ram_read_addr), .ram_read_data(ram_read_data)
    );

    initial for (int i = 0; i < MAX - 1; i++) mem[i] = '0;

    always @(posedge clk) begin
        if (ram_write_en && ram_write_addr < 32'(MAX - 1))
            mem[ram_write_addr] <= ram_write_data;
        ram_read_data <= (ram_read_addr < 32'(MAX - 1)) ? mem[ram_read_addr] : '0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Response monitor: every rsp_valid pulse must match the oldest expected response.
    always @(negedge clk) begin
        exp_t e;
        if (rsp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_err", rsp_err, e.err);
                chk("rsp_data", rsp_data, e.data);
            end
        end
    end

    task automatic chk_state();
        chk("depth", depth, stk.size());
        chk("empty", empty, stk.size() == 0);
        chk("full", full, stk.size() == MAX);
        chk("err_overflow", err_overflow, ovf_m);
        chk("err_underflow", err_underflow, unf_m);
        for (int i = 0; i < stk.size() - 1; i++)
            chk("ram_content", mem[i], stk[i]);
    endtask

    task automatic issue(input logic [1:0] op, input logic [W-1:0] d, input logic clr);
        int n;
        int sz;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (cmd_ready !== 1'b1) begin
            chk("ready_timeout", 32'd0, 32'd1);
            return;
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        err_clear = clr;
        sz = stk.size();
        #1;
        if (op == OP_PUSH) begin
            chk("ram_write_en", ram_write_en, sz > 0 && sz < MAX);
            if (sz > 0 && sz < MAX) begin
                chk("ram_write_addr", ram_write_addr, sz - 1);
                chk("ram_write_data", ram_write_data, stk[sz-1]);
            end
        end else begin
            chk("ram_write_en_idle", ram_write_en, 32'd0);
        end
        if (clr) begin
            ovf_m = 1'b0;
            unf_m = 1'b0;
        end
        case (op)
            OP_FLUSH: stk.delete();
            OP_PUSH: begin
                if (sz < MAX) stk.push_back(d);
                else ovf_m = 1'b1;
            end
            default: begin
                if (sz == 0) begin
                    unf_m = 1'b1;
                    exp_q.push_back('{err: 1'b1, data: '0});
                end else begin
                    exp_q.push_back('{err: 1'b0, data: stk[sz-1]});
                    if (op == OP_POP) void'(stk.pop_back());
                end
            end
        endcase
        @(negedge clk);
        cmd_valid = 1'b0;
        err_clear = 1'b0;
        chk("cmd_ready_after", cmd_ready, !(op == OP_POP && sz >= 2));
        chk_state();
    endtask

    initial begin
        logic [1:0] op;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = OP_FLUSH; cmd_data = '0; err_clear = 1'b0;
        ovf_m = 1'b0; unf_m = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_depth", depth, 32'd0);
        chk("rst_rsp_valid", rsp_valid, 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_cmd_ready", cmd_ready, 32'd0);
        chk("rst_ram_we", ram_write_en, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready_release", cmd_ready, 32'd1);
        chk_state();

        // basic push / peek
        issue(OP_PUSH, 16'h0010, 1'b0);
        issue(OP_PUSH, 16'h0020, 1'b0);
        issue(OP_PUSH, 16'h0030, 1'b0);
        issue(OP_PEEK, '0, 1'b0);
        // pops with refill
        repeat (3) issue(OP_POP, '0, 1'b0);
        // overflow
        issue(OP_PUSH, 16'h1111, 1'b0);
        issue(OP_PUSH, 16'h2222, 1'b0);
        issue(OP_PUSH, 16'h3333, 1'b0);
        issue(OP_PUSH, 16'h4444, 1'b0);
        issue(OP_PUSH, 16'hBEEF, 1'b0);
        issue(OP_PEEK, '0, 1'b0);
        // underflow and clear priority
        issue(OP_FLUSH, '0, 1'b0);
        issue(OP_POP, '0, 1'b0);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        ovf_m = 1'b0; unf_m = 1'b0;
        chk_state();
        issue(OP_PEEK, '0, 1'b1);
        // reset in the middle of a refill
        issue(OP_PUSH, 16'h00AA, 1'b1);
        issue(OP_PUSH, 16'h00BB, 1'b0);
        issue(OP_POP, '0, 1'b0);
        rst_n = 1'b0;
        stk.delete(); ovf_m = 1'b0; unf_m = 1'b0;
        @(negedge clk);
        chk("rst_refill_ready", cmd_ready, 32'd0);
        chk("rst_refill_depth", depth, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_refill_release", cmd_ready, 32'd1);
        chk_state();
        // flush then push must not spill stale tos
        issue(OP_PUSH, 16'h0011, 1'b0);
        issue(OP_PUSH, 16'h0022, 1'b0);
        issue(OP_PUSH, 16'h0033, 1'b0);
        issue(OP_FLUSH, '0, 1'b0);
        issue(OP_PUSH, 16'h0044, 1'b0);
        issue(OP_PEEK, '0, 1'b0);

        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 9))
                0:       op = OP_FLUSH;
                1, 2, 3: op = OP_PUSH;
                4, 5, 6: op = OP_POP;
                default: op = OP_PEEK;
            endcase
            issue(op, W'($urandom), $urandom_range(0, 15) == 0);
        end

        repeat (4) @(negedge clk);
        chk("rsp_missing", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
